// File: rtl/ram2_arbiter.sv
// ram2_arbiter: shares the single-ported RAM2 SRAM between instruction fetch and
// the MEM stage, sequencing SRAM strobes and stalling the pipeline while either side waits.
module ram2_arbiter #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_inst,
    output logic        if_ack,
    input  logic        mem_ce,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_data_i,
    output logic [15:0] mem_data_o,
    output logic        mem_ack,
    output logic        stall_req,
    output logic [17:0] ram2_addr,
    inout  wire  [15:0] ram2_data,
    output logic        ram2_en_n,
    output logic        ram2_oe_n,
    output logic        ram2_we_n
);

    localparam logic        RAM_CHIP_ENABLE  = 1'b1;
    localparam logic        RAM_READ_ENABLE  = 1'b1;
    localparam logic        RAM_WRITE_ENABLE = 1'b1;
    localparam logic [15:0] ZERO_WORD        = 16'h0000;
    localparam logic [15:0] NOP_INST         = 16'h0800;
    localparam logic [7:0]  RD_CNT           = 8'(RD_WAIT);
    localparam logic [7:0]  WR_CNT           = 8'(WR_WAIT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_mem_q, last_mem_d;
    logic        owner_if_q, owner_if_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] if_inst_q, if_inst_d;
    logic [15:0] mem_data_q, mem_data_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        en_n_q, en_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;

    logic mem_req_s, mem_wr_s, if_pend_s, mem_pend_s, grant_if_s, grant_mem_s;

    // A requester whose ack is showing this cycle is not pending again, so it cannot be regranted twice.
    assign mem_req_s   = (mem_ce == RAM_CHIP_ENABLE) &&
                         ((mem_re == RAM_READ_ENABLE) || (mem_we == RAM_WRITE_ENABLE));
    assign mem_wr_s    = (mem_we == RAM_WRITE_ENABLE);
    assign if_pend_s   = if_req && !if_ack_q;
    assign mem_pend_s  = mem_req_s && !mem_ack_q;
    assign grant_if_s  = if_pend_s && (!mem_pend_s || last_mem_q);
    assign grant_mem_s = mem_pend_s && !grant_if_s;

    assign stall_req  = if_pend_s || mem_pend_s;
    assign if_inst    = if_inst_q;
    assign if_ack     = if_ack_q;
    assign mem_data_o = mem_data_q;
    assign mem_ack    = mem_ack_q;
    assign ram2_addr  = {2'b00, addr_q};
    assign ram2_en_n  = en_n_q;
    assign ram2_oe_n  = oe_n_q;
    assign ram2_we_n  = we_n_q;
    assign ram2_data  = drive_q ? wdata_q : 16'hzzzz;

    // Next-state, counter and capture logic; SRAM strobes follow the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_mem_d = last_mem_q;
        owner_if_d = owner_if_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_inst_d  = if_inst_q;
        mem_data_d = mem_data_q;
        if_ack_d   = 1'b0;
        mem_ack_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_if_s) begin
                    state_d    = S_RD;
                    cnt_d      = RD_CNT;
                    owner_if_d = 1'b1;
                    last_mem_d = 1'b0;
                    addr_d     = if_addr;
                end else if (grant_mem_s) begin
                    owner_if_d = 1'b0;
                    last_mem_d = 1'b1;
                    addr_d     = mem_addr_i;
                    if (mem_wr_s) begin
                        state_d = S_WR_SETUP;
                        wdata_d = mem_data_i;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = RD_CNT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    if (owner_if_q) begin
                        if_inst_d = ram2_data;
                        if_ack_d  = 1'b1;
                    end else begin
                        mem_data_d = ram2_data;
                        mem_ack_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WR_CNT;
            end
            S_WR_PULSE: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WR_HOLD: begin
                state_d   = S_IDLE;
                mem_ack_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        en_n_d  = (state_d == S_IDLE);
        oe_n_d  = (state_d != S_RD);
        we_n_d  = (state_d != S_WR_PULSE);
        drive_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    end

    // State and output registers with synchronous active-low reset that aborts any access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            last_mem_q <= 1'b0;
            owner_if_q <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            if_inst_q  <= NOP_INST;
            mem_data_q <= ZERO_WORD;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            en_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_mem_q <= last_mem_d;
            owner_if_q <= owner_if_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_inst_q  <= if_inst_d;
            mem_data_q <= mem_data_d;
            if_ack_q   <= if_ack_d;
            mem_ack_q  <= mem_ack_d;
            en_n_q     <= en_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            drive_q    <= drive_d;
        end
    end

endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter: table-driven and randomized bench for ram2_arbiter with an SRAM
// model on the pins and a request-level reference model of arbitration order and data.
module tb_ram2_arbiter;

    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 1;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        mem_ce, mem_re, mem_we;
    logic [15:0] mem_addr_i, mem_data_i;
    wire  [15:0] if_inst, mem_data_o;
    wire         if_ack, mem_ack, stall_req;
    wire  [17:0] ram2_addr;
    wire  [15:0] ram2_data;
    wire         ram2_en_n, ram2_oe_n, ram2_we_n;

    int n_cmp = 0;
    int n_fail = 0;

    ram2_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_ack(if_ack),
        .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .mem_ack(mem_ack), .stall_req(stall_req),
        .ram2_addr(ram2_addr), .ram2_data(ram2_data),
        .ram2_en_n(ram2_en_n), .ram2_oe_n(ram2_oe_n), .ram2_we_n(ram2_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of the SRAM chip.
    function automatic logic [15:0] dflt(input logic [15:0] a);
        if (a == 16'h0003) return 16'hE151;
        return a ^ 16'hA5A5;
    endfunction

    // SRAM chip model on the RAM2 pins
    logic [15:0] sram    [0:65535];
    bit          sram_wr [0:65535];

    function automatic logic [15:0] sram_rd(input logic [15:0] a);
        return sram_wr[a] ? sram[a] : dflt(a);
    endfunction

    assign ram2_data = (!ram2_en_n && !ram2_oe_n) ? sram_rd(ram2_addr[15:0]) : 16'hzzzz;

    always @(posedge clk) begin
        if (!ram2_en_n && !ram2_we_n) begin
            sram[ram2_addr[15:0]]    <= ram2_data;
            sram_wr[ram2_addr[15:0]] <= 1'b1;
        end
    end

    // Reference model: expected memory contents and last-grant history
    logic [15:0] ref_mem [0:65535];
    bit          ref_wr  [0:65535];
    bit          m_last_mem = 1'b0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_wr[a] ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("oe_we_overlap", {31'd0, (!ram2_oe_n && !ram2_we_n)}, 32'd0);
        chk("addr_hi_zero", {30'd0, ram2_addr[17:16]}, 32'd0);
    end

    // One round: optional IF fetch plus 0..2 MEM accesses (the second re-requested right after
    // the first ack). Expected order and data come from the reference model.
    task automatic do_round(input bit w_if, input logic [15:0] ia, input int n_mem,
                            input bit wr, input bit both,
                            input logic [15:0] ma, input logic [15:0] md,
                            output int lat, output logic [3:0] ord, output logic [15:0] last_d,
                            output int oe_cnt, output int we_cnt, output int drv_cnt);
        bit          p_if;
        int          ml, k, mem_k;
        bit          exp_ord[$];
        logic [15:0] exp_d[$];
        logic [15:0] a, d;
        bit          if_done, e;
        logic        s_if_ack, s_mem_ack, s_stall;
        logic [15:0] s_if_inst, s_mem_data;
        bit          done;

        p_if = w_if; ml = n_mem; k = 0;
        while (p_if || ml > 0) begin
            if (p_if && (ml == 0 || m_last_mem)) begin
                exp_ord.push_back(1'b0);
                exp_d.push_back(ref_rd(ia));
                p_if = 1'b0;
                m_last_mem = 1'b0;
            end else begin
                a = ma + 16'(k);
                d = md + 16'(k);
                if (wr) begin
                    ref_mem[a] = d;
                    ref_wr[a]  = 1'b1;
                    exp_d.push_back(d);
                end else begin
                    exp_d.push_back(ref_rd(a));
                end
                exp_ord.push_back(1'b1);
                k++; ml--;
                m_last_mem = 1'b1;
            end
        end

        if_req     = w_if;
        if_addr    = ia;
        mem_ce     = (n_mem > 0);
        mem_re     = (n_mem > 0) && (!wr || both);
        mem_we     = (n_mem > 0) && wr;
        mem_addr_i = ma;
        mem_data_i = md;
        mem_k = 0; if_done = 1'b0; lat = 0; ord = 4'd0; last_d = 16'h0000;
        oe_cnt = 0; we_cnt = 0; drv_cnt = 0; done = 1'b0;

        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk); #1;
            s_if_ack = if_ack; s_mem_ack = mem_ack; s_stall = stall_req;
            s_if_inst = if_inst; s_mem_data = mem_data_o;
            if (!ram2_oe_n) oe_cnt++;
            if (!ram2_we_n) we_cnt++;
            if (!ram2_en_n && ram2_oe_n && ram2_data === mem_data_i) drv_cnt++;
            if (s_if_ack === 1'b1) begin
                if (lat == 0) lat = cyc;
                ord = {ord[2:0], 1'b0};
                e = (exp_ord.size() > 0) ? exp_ord.pop_front() : 1'b1;
                chk("ack_order_if", 32'd0, {31'd0, e});
                last_d = s_if_inst;
                chk("if_inst", {16'd0, s_if_inst}, {16'd0, (exp_d.size() > 0) ? exp_d.pop_front() : 16'hxxxx});
                if_done = 1'b1;
                if_req  = 1'b0;
            end
            if (s_mem_ack === 1'b1) begin
                if (lat == 0) lat = cyc;
                ord = {ord[2:0], 1'b1};
                e = (exp_ord.size() > 0) ? exp_ord.pop_front() : 1'b0;
                chk("ack_order_mem", 32'd1, {31'd0, e});
                last_d = s_mem_data;
                if (wr) begin
                    void'(exp_d.pop_front());
                end else begin
                    chk("mem_data_o", {16'd0, s_mem_data}, {16'd0, (exp_d.size() > 0) ? exp_d.pop_front() : 16'hxxxx});
                end
                mem_k++;
                if (mem_k < n_mem) begin
                    mem_addr_i = ma + 16'(mem_k);
                    mem_data_i = md + 16'(mem_k);
                end else begin
                    mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
                end
            end
            chk("stall_req", {31'd0, s_stall},
                {31'd0, ((w_if && !if_done) || (mem_k < n_mem && s_mem_ack !== 1'b1))});
            done = (!w_if || if_done) && (mem_k == n_mem);
        end
        chk("round_complete", {31'd0, done}, 32'd1);
        chk("all_served", exp_ord.size(), 32'd0);
        if_req = 1'b0; mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("idle_acks", {30'd0, if_ack, mem_ack}, 32'd0);
        chk("idle_stall", {31'd0, stall_req}, 32'd0);
    endtask

    typedef struct {
        bit          is_mem;
        bit          wr;
        bit          both;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
    } vec_t;

    vec_t        tbl[9];
    int          lat, oe_c, we_c, drv_c;
    logic [3:0]  ord;
    logic [15:0] ld;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'hE151};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h00FF, 16'h5555, 16'h5555};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h5555};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'hB791};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'h1111, 16'h1111};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1111};

        rst = 1'b0; if_req = 1'b0; if_addr = 16'h0000;
        mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        mem_addr_i = 16'h0000; mem_data_i = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_inst", {16'd0, if_inst}, 32'h0800);
        chk("rst_mem_data", {16'd0, mem_data_o}, 32'h0000);
        chk("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
        chk("rst_strobes", {29'd0, ram2_en_n, ram2_oe_n, ram2_we_n}, 32'd7);
        chk("rst_addr", {14'd0, ram2_addr}, 32'd0);
        chk("rst_data_z", {31'd0, (ram2_data === 16'hzzzz)}, 32'd1);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_round(!tbl[i].is_mem, tbl[i].addr, tbl[i].is_mem ? 1 : 0, tbl[i].wr, tbl[i].both,
                     tbl[i].addr, tbl[i].wdata, lat, ord, ld, oe_c, we_c, drv_c);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].wr ? WR_WAIT + 3 : RD_WAIT + 2);
            chk($sformatf("tbl%0d_oe_cycles", i), oe_c, tbl[i].wr ? 0 : RD_WAIT + 1);
            chk($sformatf("tbl%0d_we_cycles", i), we_c, tbl[i].wr ? WR_WAIT : 0);
            chk($sformatf("tbl%0d_drive_cycles", i), drv_c, tbl[i].wr ? WR_WAIT + 2 : 0);
            if (tbl[i].wr) begin
                chk($sformatf("tbl%0d_sram", i), {16'd0, sram_rd(tbl[i].addr)}, {16'd0, tbl[i].exp_data});
            end else begin
                chk($sformatf("tbl%0d_data", i), {16'd0, ld}, {16'd0, tbl[i].exp_data});
            end
        end

        // Simultaneous IF and MEM read after an IF grant: MEM goes first
        do_round(1'b1, 16'h0004, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, lat, ord, ld, oe_c, we_c, drv_c);
        do_round(1'b1, 16'h0004, 1, 1'b0, 1'b0, 16'h00FF, 16'h0000, lat, ord, ld, oe_c, we_c, drv_c);
        chk("simult_order", {28'd0, ord}, 32'b0010);
        chk("simult_if_data", {16'd0, ld}, {16'd0, dflt(16'h0004)});

        // Back-to-back MEM reads with if_req held: IF slips in between
        do_round(1'b1, 16'h0005, 2, 1'b0, 1'b0, 16'h0020, 16'h0000, lat, ord, ld, oe_c, we_c, drv_c);
        chk("b2b_order", {28'd0, ord}, 32'b0101);

        for (int r = 0; r < 30; r++) begin
            bit wi, w, b;
            int nm;
            wi = 1'($urandom_range(0, 1));
            nm = $urandom_range(0, 2);
            if (!wi && nm == 0) nm = 1;
            w = 1'($urandom_range(0, 1));
            b = w & 1'($urandom_range(0, 1));
            do_round(wi, 16'($urandom_range(0, 15)), nm, w, b, 16'($urandom_range(0, 15)),
                     16'($urandom), lat, ord, ld, oe_c, we_c, drv_c);
        end

        // Reset during the write pulse aborts the access without an ack
        mem_ce = 1'b1; mem_re = 1'b0; mem_we = 1'b1;
        mem_addr_i = 16'h0100; mem_data_i = 16'hA1A1;
        @(posedge clk); #1;
        chk("abort_setup_we", {31'd0, ram2_we_n}, 32'd1);
        @(posedge clk); #1;
        chk("abort_pulse_we", {31'd0, ram2_we_n}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_we_n", {31'd0, ram2_we_n}, 32'd1);
        chk("abort_en_n", {31'd0, ram2_en_n}, 32'd1);
        chk("abort_data_z", {31'd0, (ram2_data === 16'hzzzz)}, 32'd1);
        chk("abort_no_ack", {31'd0, mem_ack}, 32'd0);
        chk("abort_if_inst", {16'd0, if_inst}, 32'h0800);
        mem_ce = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_ack_later", {31'd0, mem_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_last_mem = 1'b0;
        ref_mem[16'h0100] = 16'hA1A1;
        ref_wr[16'h0100]  = 1'b1;
        do_round(1'b1, 16'h0100, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, lat, ord, ld, oe_c, we_c, drv_c);
        chk("post_abort_latency", lat, RD_WAIT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
